digest_serializer: RTL
======================

Name: digest_serializer

Overview:
Downstream of the hashing control FSM. Captures the full N_BYTES hash state on the one-cycle digest_ready pulse. Streams it out one byte per transfer over a valid/ready byte interface to the host/UART side. A one-entry pending buffer absorbs a second digest that arrives while streaming; anything beyond that is dropped and flagged.

Parameters:
N_BYTES, 8, number of hash bytes H[0..N_BYTES-1] in a digest
MSB_FIRST, 0, 0: stream H[0] first; 1: stream H[N_BYTES-1] first

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
digest_ready  in  1  one-cycle pulse from control FSM: digest_in is valid this cycle
digest_in  in  8*N_BYTES  hash state; H[i] = digest_in[8*i+7:8*i]
out_ready  in  1  downstream accepts out_byte this cycle
clear_overrun  in  1  synchronous clear of the overrun flag
out_byte  out  8  current digest byte
out_valid  out  1  out_byte valid
out_last  out  1  out_byte is the final byte of the current digest
busy  out  1  high while streaming or pending_full
pending_full  out  1  a second digest is queued
overrun  out  1  sticky: a digest was dropped
digest_sent  out  1  one-cycle pulse on the transfer of the last byte

Behaviour:
- Reset (async, active-high, any time including mid-stream): state IDLE, byte index 0, both buffers cleared to 0. Outputs: out_byte=0, out_valid=0, out_last=0, busy=0, pending_full=0, overrun=0, digest_sent=0. A partially sent digest is abandoned.
- Transfer = out_valid && out_ready on a rising edge.
- States:
  - IDLE: out_valid=0.
  - STREAM: out_valid=1.
- IDLE + digest_ready: load digest_in into the shadow register, idx=0, go to STREAM. out_valid rises the cycle after digest_ready (latency 1).
- STREAM output mapping: out_byte = shadow byte idx when MSB_FIRST=0, byte N_BYTES-1-idx when MSB_FIRST=1. out_last = (idx==N_BYTES-1).
  - out_byte and out_last are registered and hold stable while out_valid && !out_ready.
  - idx increments only on a transfer.
- Transfer with out_last=1: digest_sent=1 for that cycle (combinational with the transfer, registered counterpart not required). Then:
  - pending_full=1: load pending into shadow, idx=0, clear pending_full, stay in STREAM. There is no idle gap; out_valid stays 1.
  - pending_full=0 and no digest_ready: go to IDLE; out_valid=0 next cycle.
- digest_ready in STREAM:
  - pending_full=0: capture into pending, set pending_full.
  - pending_full=1: drop the new digest, set overrun.
- Simultaneous digest_ready and last-byte transfer:
  - pending empty: new digest goes straight to shadow, idx=0, stay in STREAM, no overrun.
  - pending full: pending moves to shadow, new digest goes to pending, pending_full stays 1, no overrun.
- overrun: set as above, held until clear_overrun or reset. If set and clear occur in the same cycle, set wins.
- busy = (state==STREAM) || pending_full.
- idx width: clog2(N_BYTES). Never exceeds N_BYTES-1; it wraps to 0 only via a reload.

Test Plan:
- Basic stream: reset, digest_in=0x0807060504030201, pulse, out_ready=1 -> bytes 01,02,...,08 on 8 consecutive cycles; out_last and digest_sent only with 08; out_valid first high 1 cycle after pulse.
- MSB_FIRST=1 with the same digest -> bytes 08,07,...,01; out_last with 01.
- Backpressure: toggle out_ready 1,0,0,1,... -> out_byte/out_last constant while stalled; all 8 bytes delivered once, in order, none duplicated.
- Pending: second digest 0x1111...11 pulsed at byte 3 of the first -> pending_full=1; after first 08 the next cycle shows 11 with out_valid never dropping; 16 transfers total; overrun=0.
- Overrun + simultaneity: with pending full, pulse a third digest -> overrun=1, third never output. clear_overrun -> 0. A pulse on the last-byte transfer cycle with pending empty -> immediate restart, overrun stays 0.
- Reset mid-stream after 4 bytes -> all outputs 0 the same cycle reset asserts; after release, idle until a new pulse.

Source files
------------

// File: rtl/digest_serializer.sv
// Captures an N_BYTES hash digest on a one-cycle pulse and streams it out
// one byte per valid/ready transfer, with a one-entry pending buffer.
module digest_serializer #(
    parameter int unsigned N_BYTES   = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 digest_ready,
    input  logic [8*N_BYTES-1:0] digest_in,
    input  logic                 out_ready,
    input  logic                 clear_overrun,
    output logic [7:0]           out_byte,
    output logic                 out_valid,
    output logic                 out_last,
    output logic                 busy,
    output logic                 pending_full,
    output logic                 overrun,
    output logic                 digest_sent
);

    localparam int unsigned DW       = 8 * N_BYTES;
    localparam int unsigned IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned LAST_IDX = N_BYTES - 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n, idx_inc;
    logic [DW-1:0]    shadow, shadow_n;
    logic [DW-1:0]    pending, pending_n;
    logic             pending_full_n;
    logic             overrun_n;
    logic             overrun_set;
    logic [7:0]       out_byte_n;
    logic             out_last_n;
    logic             xfer;
    logic             last_xfer;

    // Byte lane for stream position i, honouring the configured byte order.
    function automatic logic [7:0] pick(input logic [DW-1:0] d, input logic [IDX_W-1:0] i);
        int unsigned pos;
        pos = MSB_FIRST ? (LAST_IDX - 32'(i)) : 32'(i);
        return d[8*pos +: 8];
    endfunction

    assign out_valid   = (state == STREAM);
    assign busy        = (state == STREAM) || pending_full;
    assign xfer        = out_valid && out_ready;
    assign last_xfer   = xfer && out_last;
    assign digest_sent = last_xfer;
    assign idx_inc     = idx + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            shadow       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            overrun      <= 1'b0;
            out_byte     <= '0;
            out_last     <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            shadow       <= shadow_n;
            pending      <= pending_n;
            pending_full <= pending_full_n;
            overrun      <= overrun_n;
            out_byte     <= out_byte_n;
            out_last     <= out_last_n;
        end
    end

    always_comb begin
        state_n        = state;
        idx_n          = idx;
        shadow_n       = shadow;
        pending_n      = pending;
        pending_full_n = pending_full;
        out_byte_n     = out_byte;
        out_last_n     = out_last;
        overrun_set    = 1'b0;

        unique case (state)
            IDLE: begin
                if (digest_ready) begin
                    state_n    = STREAM;
                    shadow_n   = digest_in;
                    idx_n      = '0;
                    out_byte_n = pick(digest_in, '0);
                    out_last_n = (N_BYTES == 1);
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    // End of digest: chain straight into the next one if any is waiting.
                    idx_n      = '0;
                    out_last_n = (N_BYTES == 1);
                    if (pending_full) begin
                        shadow_n   = pending;
                        out_byte_n = pick(pending, '0);
                        if (digest_ready) begin
                            pending_n = digest_in;
                        end else begin
                            pending_full_n = 1'b0;
                        end
                    end else if (digest_ready) begin
                        shadow_n   = digest_in;
                        out_byte_n = pick(digest_in, '0);
                    end else begin
                        state_n    = IDLE;
                        out_byte_n = '0;
                        out_last_n = 1'b0;
                    end
                end else begin
                    if (xfer) begin
                        idx_n      = idx_inc;
                        out_byte_n = pick(shadow, idx_inc);
                        out_last_n = (idx_inc == IDX_W'(LAST_IDX));
                    end
                    if (digest_ready) begin
                        if (pending_full) begin
                            overrun_set = 1'b1;
                        end else begin
                            pending_n      = digest_in;
                            pending_full_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A new drop outranks a simultaneous clear.
        if (overrun_set) begin
            overrun_n = 1'b1;
        end else if (clear_overrun) begin
            overrun_n = 1'b0;
        end else begin
            overrun_n = overrun;
        end
    end

endmodule
